mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the processor control unit's memory strobes (enmem/wrmem).
- Services one read or write per transaction against an internal RAM, with a configurable number of wait states.
- Uses a four-phase enmem/ack handshake, so the control FSM can stall until the access completes.
- Sits between the control FSM and datapath: address comes from the PC/operand mux, write data from the ALU result, and rdata feeds the IR and operand registers.

Parameters:
- DATA_W, 8: data word width.
- ADDR_W, 4: address width.
- DEPTH, 16: number of implemented words, 1..2^ADDR_W; addresses >= DEPTH are out of range.
- WAIT_STATES, 1: extra cycles between request acceptance and access, 0..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enmem  in  1  request level from initiator; held high until ack is seen, then dropped.
- wrmem  in  1  1 = write, 0 = read; sampled only at acceptance.
- addr  in  ADDR_W  word address; sampled at acceptance.
- wdata  in  DATA_W  write data; sampled at acceptance.
- rdata  out  DATA_W  read data; valid while ack=1 for a read, holds its value until the next read completes.
- ack  out  1  access complete; stays high until enmem is sampled low.
- err  out  1  qualifies ack: 1 = address was out of range.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0. RAM contents are not cleared by reset.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with enmem=1: latch addr, wdata, wrmem.
  - If WAIT_STATES>0: load counter=WAIT_STATES-1 and go to WAIT.
  - Otherwise perform the access at this edge and go to ACK.
- WAIT: each edge decrements the counter. At the edge where the counter is 0, perform the access and go to ACK.
- Access:
  - Write with in-range address: RAM[addr_l] <= wdata_l; rdata unchanged.
  - Read with in-range address: rdata <= RAM[addr_l].
  - Out of range: no RAM write, rdata <= 0 (reads only), err <= 1.
- ACK: ack=1; err valid. On an edge with enmem=0: go to IDLE, ack<=0, err<=0. Otherwise stay in ACK.
- Latency: if enmem first rises before edge E0, ack is high after edge E0+WAIT_STATES, i.e. WAIT_STATES+1 cycles.
- A new request is accepted no earlier than the edge after the return to IDLE. A request can never be duplicated by an enmem held high.
- enmem dropping during WAIT is a protocol violation. The responder still completes the access, enters ACK, and returns to IDLE at the next edge, where enmem is sampled low. ack is high for exactly one cycle in this case.
- Changes on addr, wdata or wrmem after acceptance are ignored.
- Reset mid-transaction (WAIT or ACK): abort immediately; no write occurs unless the access edge has already passed.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Decomposition:
- Shared package (cpu_pkg) holds:
  - default DATA_W/ADDR_W;
  - responder state encodings IDLE=2'b00, WAIT=2'b01, ACK=2'b10;
  - the operation codes SUM/RES/MOV/OUT, so control and memory blocks agree on widths.
- One sub-module, mem_array: DEPTH x DATA_W storage with a synchronous write port (we, waddr, wdata) and a synchronous read port (re, raddr, rdata_q).
- mem_responder keeps the handshake FSM, wait counter, range check and output registers.

Test Plan:
- Reset with rst_n=0 mid-WAIT, asserted between edges -> ack=0, busy=0, rdata=0 immediately, before the next edge; a following read of a never-written address still completes with ack.
- WAIT_STATES=1: write addr=3, wdata=8'hA5 (enmem held) -> ack high after 2 cycles and holds until enmem drops; then read addr=3 -> rdata=8'hA5, err=0.
- WAIT_STATES=0: back-to-back reads of addr 0 and 1 (preloaded 8'h11, 8'h22), enmem dropped for one cycle between them -> ack one cycle after each request; rdata 8'h11 then 8'h22; busy=0 only in the gap cycle.
- Initiator holds enmem high 5 cycles past ack -> ack stays high 5 cycles; exactly one RAM write occurs (verify the old value is unaffected by a second write attempt with different wdata).
- DEPTH=12: write addr=13, wdata=8'hFF, then read addr=13 -> both ack with err=1; the read returns rdata=0; a read of addr=1 confirms no aliasing write.
- Change addr and wdata on the cycle after acceptance (WAIT_STATES=3) -> the originally sampled address/data is written; busy=1 for 4 cycles before ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and defaults shared between the control unit and the memory responder,
// so both sides agree on widths and encodings.
package cpu_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'b00,
    RSP_WAIT = 2'b01,
    RSP_ACK  = 2'b10
  } rsp_state_e;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_RES = 2'b01,
    OP_MOV = 2'b10,
    OP_OUT = 2'b11
  } op_e;
endpackage

// File: rtl/mem_responder_if.sv
// enmem/ack memory strobe bus between the control FSM (master) and the responder (slave).
interface mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              enmem;
  logic              wrmem;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (output enmem, wrmem, addr, wdata, input rdata, ack, err, busy);
  modport slave  (input enmem, wrmem, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage, one synchronous write and one synchronous read port.
// Contents are deliberately not reset.
module mem_array #(
  parameter int          DATA_W = 8,
  parameter int          ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_q
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: four-phase enmem/ack handshake with configurable wait
// states, range check and a held read-data output.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  rsp_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              wr_l;
  logic              err_q;
  logic              rd_zero;
  logic [DATA_W-1:0] rdata_q;

  logic              in_idle, acc, acc_wr, acc_ok, we, re;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RSP_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RSP_IDLE: if (bus.enmem) state_nx = NO_WAIT ? RSP_ACK : RSP_WAIT;
      RSP_WAIT: if (cnt == '0) state_nx = RSP_ACK;
      RSP_ACK:  if (!bus.enmem) state_nx = RSP_IDLE;
      default:  state_nx = RSP_IDLE;
    endcase
  end

  // With no wait states the access happens on the acceptance edge, so it must
  // use the live bus fields rather than the latched copies.
  always_comb begin
    in_idle   = (state == RSP_IDLE);
    acc       = (in_idle && bus.enmem && NO_WAIT) || (state == RSP_WAIT && cnt == '0);
    acc_addr  = in_idle ? bus.addr  : addr_l;
    acc_wdata = in_idle ? bus.wdata : wdata_l;
    acc_wr    = in_idle ? bus.wrmem : wr_l;
    acc_ok    = 32'(acc_addr) < DEPTH;
    we        = acc && acc_wr && acc_ok;
    re        = acc && !acc_wr && acc_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_l  <= '0;
      wdata_l <= '0;
      wr_l    <= 1'b0;
      err_q   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      if (in_idle && bus.enmem) begin
        addr_l  <= bus.addr;
        wdata_l <= bus.wdata;
        wr_l    <= bus.wrmem;
        cnt     <= CNT_W'(WAIT_STATES - 1);
      end else if (state == RSP_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (acc) begin
        err_q <= !acc_ok;
        if (!acc_wr) rd_zero <= !acc_ok;
      end
      if (state == RSP_ACK && !bus.enmem) err_q <= 1'b0;
    end
  end

  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (acc_addr),
    .wdata   (acc_wdata),
    .re      (re),
    .raddr   (acc_addr),
    .rdata_q (rdata_q)
  );

  // rd_zero masks the array output after reset and after out-of-range reads.
  assign bus.rdata = rd_zero ? '0 : rdata_q;
  assign bus.ack   = (state == RSP_ACK);
  assign bus.busy  = (state != RSP_IDLE);
  assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover WAIT_STATES 1/0/3
// and DEPTH 16/12.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en [3];
  logic       wr [3];
  logic [3:0] ad [3];
  logic [7:0] wd [3];
  logic [7:0] rdata [3];
  logic       ack [3];
  logic       err [3];
  logic       busy [3];

  int n_chk = 0;
  int n_fail = 0;

  mem_responder_if #(.DATA_W(8), .ADDR_W(4)) b0 ();
  mem_responder_if #(.DATA_W(8), .ADDR_W(4)) b1 ();
  mem_responder_if #(.DATA_W(8), .ADDR_W(4)) b2 ();

  assign b0.enmem = en[0]; assign b0.wrmem = wr[0]; assign b0.addr = ad[0]; assign b0.wdata = wd[0];
  assign b1.enmem = en[1]; assign b1.wrmem = wr[1]; assign b1.addr = ad[1]; assign b1.wdata = wd[1];
  assign b2.enmem = en[2]; assign b2.wrmem = wr[2]; assign b2.addr = ad[2]; assign b2.wdata = wd[2];
  assign rdata[0] = b0.rdata; assign ack[0] = b0.ack; assign err[0] = b0.err; assign busy[0] = b0.busy;
  assign rdata[1] = b1.rdata; assign ack[1] = b1.ack; assign err[1] = b1.err; assign busy[1] = b1.busy;
  assign rdata[2] = b2.rdata; assign ack[2] = b2.ack; assign err[2] = b2.err; assign busy[2] = b2.busy;

  mem_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .WAIT_STATES(0)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(3)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full handshake; ack must arrive exp_lat edges after enmem rises.
  // During a hold the write data is changed to prove no second write happens.
  task automatic txn(input int d, input bit w, input logic [3:0] a, input logic [7:0] v,
                     input int hold, input int exp_lat,
                     output logic [7:0] rd, output logic e);
    int n = 0;
    en[d] = 1'b1; wr[d] = w; ad[d] = a; wd[d] = v;
    do begin tick(); n++; end while (!ack[d] && n < 40);
    chk("latency", n, exp_lat);
    chk("busy_at_ack", busy[d], 1);
    rd = rdata[d];
    e  = err[d];
    for (int i = 0; i < hold; i++) begin
      wd[d] = ~v;
      tick();
      chk("ack_hold", ack[d], 1);
    end
    en[d] = 1'b0;
    tick();
    chk("ack_drop", ack[d], 0);
    chk("busy_gap", busy[d], 0);
    chk("err_drop", err[d], 0);
  endtask

  logic [7:0] rd;
  logic       e;
  int         n, acks;

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    repeat (2) tick();
    chk("rst_ack", ack[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_rdata", rdata[0], 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted between edges while in WAIT.
    en[0] = 1'b1; wr[0] = 1'b0; ad[0] = 4'd7;
    tick();
    chk("wait_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_rdata", rdata[0], 0);
    en[0] = 1'b0;
    #1 rst_n = 1'b1;
    txn(0, 1'b0, 4'd7, 8'h00, 0, 2, rd, e);
    chk("unwritten_err", e, 0);

    // WAIT_STATES=1 write then read back.
    txn(0, 1'b1, 4'd3, 8'hA5, 0, 2, rd, e);
    chk("w3_err", e, 0);
    txn(0, 1'b0, 4'd3, 8'h00, 0, 2, rd, e);
    chk("r3_data", rd, 8'hA5);
    chk("r3_err", e, 0);

    // enmem held 5 cycles past ack: single write, rdata untouched by writes.
    txn(0, 1'b1, 4'd5, 8'h3C, 5, 2, rd, e);
    chk("w5_rdata_held", rd, 8'hA5);
    txn(0, 1'b0, 4'd5, 8'h00, 0, 2, rd, e);
    chk("r5_data", rd, 8'h3C);

    // WAIT_STATES=0, DEPTH=12.
    txn(1, 1'b1, 4'd0, 8'h11, 0, 1, rd, e);
    txn(1, 1'b1, 4'd1, 8'h22, 0, 1, rd, e);
    txn(1, 1'b0, 4'd0, 8'h00, 0, 1, rd, e);
    chk("r0_data", rd, 8'h11);
    txn(1, 1'b0, 4'd1, 8'h00, 0, 1, rd, e);
    chk("r1_data", rd, 8'h22);
    txn(1, 1'b1, 4'd13, 8'hFF, 0, 1, rd, e);
    chk("w13_err", e, 1);
    txn(1, 1'b0, 4'd13, 8'h00, 0, 1, rd, e);
    chk("r13_err", e, 1);
    chk("r13_data", rd, 8'h00);
    txn(1, 1'b0, 4'd1, 8'h00, 0, 1, rd, e);
    chk("r1_noalias", rd, 8'h22);
    chk("r1_err", e, 0);
    txn(1, 1'b1, 4'd11, 8'h5A, 0, 1, rd, e);
    chk("w11_err", e, 0);
    txn(1, 1'b0, 4'd11, 8'h00, 0, 1, rd, e);
    chk("r11_data", rd, 8'h5A);
    txn(1, 1'b0, 4'd12, 8'h00, 0, 1, rd, e);
    chk("r12_err", e, 1);
    chk("r12_data", rd, 8'h00);

    // WAIT_STATES=3: bus fields change right after acceptance.
    en[2] = 1'b1; wr[2] = 1'b1; ad[2] = 4'd9; wd[2] = 8'h77;
    n = 0;
    do begin
      tick(); n++;
      chk("w9_busy", busy[2], 1);
      if (n == 1) begin ad[2] = 4'd2; wd[2] = 8'h88; wr[2] = 1'b0; end
    end while (!ack[2] && n < 40);
    chk("w9_latency", n, 4);
    en[2] = 1'b0;
    tick();
    chk("w9_drop", ack[2], 0);
    txn(2, 1'b0, 4'd9, 8'h00, 0, 4, rd, e);
    chk("r9_data", rd, 8'h77);

    // enmem dropped during WAIT: access still completes, ack for one cycle.
    en[2] = 1'b1; wr[2] = 1'b0; ad[2] = 4'd9;
    tick();
    en[2] = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack[2]) begin
        acks++;
        chk("viol_data", rdata[2], 8'h77);
      end
    end
    chk("viol_ack_cycles", acks, 1);
    chk("viol_idle", busy[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
